// File: rtl/qam_s2p_diff.sv
// Serial-to-parallel QAM symbol mapper: BPS serial bits -> I/Q level indices, valid/ready on both sides.
// Define QAM_S2P_DIFF_EN to build the modulo-2^BPS differential encoder with Gray output mapping.
module qam_s2p_diff #(
  parameter int BPS       = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [BPS/2-1:0] sym_i,
  output logic [BPS/2-1:0] sym_q,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int            CW       = $clog2(BPS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS - 1);

  logic [CW-1:0]  cnt_p0;
  logic [BPS-1:0] asm_p0;
  logic [BPS-1:0] word_p1;
  logic           vld_p1;

  logic           out_free, full, accept, xfer_a, xfer_b, xfer;
  logic [BPS-1:0] asm_wr, raw_word, enc_word;
  logic [CW-1:0]  cnt_nxt;

  function automatic logic [BPS-1:0] gray_enc(input logic [BPS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Carry out of the top bit is dropped, giving the modulo-2^BPS sum.
  function automatic logic [BPS-1:0] wrap_add(input logic [BPS-1:0] a, input logic [BPS-1:0] b);
    return a + b;
  endfunction

  function automatic int bit_pos(input logic [CW-1:0] c);
    return LSB_FIRST ? int'(c) : BPS - 1 - int'(c);
  endfunction

  always_comb begin
    out_free = !vld_p1 || out_ready;
    full     = (cnt_p0 == CNT_FULL);
    in_ready = !full || out_free;
    accept   = in_valid && in_ready;
    xfer_a   = accept && (cnt_p0 == CNT_LAST) && out_free;
    xfer_b   = full && out_free;
    xfer     = xfer_a || xfer_b;

    // A bit accepted while full always coincides with a transfer, so it starts the next word.
    asm_wr = asm_p0;
    if (accept) begin
      for (int k = 0; k < BPS; k++) begin
        if (k == bit_pos(full ? '0 : cnt_p0)) asm_wr[k] = in_bit;
      end
    end
    raw_word = xfer_b ? asm_p0 : asm_wr;

    if (xfer_b)      cnt_nxt = accept ? CW'(1) : '0;
    else if (xfer_a) cnt_nxt = '0;
    else if (accept) cnt_nxt = cnt_p0 + 1'b1;
    else             cnt_nxt = cnt_p0;
  end

`ifdef QAM_S2P_DIFF_EN
  logic [BPS-1:0] acc_p1, acc_base, acc_nxt;

  // A clear coinciding with a transfer zeroes the reference before the new word is added.
  always_comb begin
    acc_base = acc_clr ? '0 : acc_p1;
    acc_nxt  = wrap_add(acc_base, raw_word);
    enc_word = gray_enc(acc_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc_p1 <= '0;
    else if (xfer)    acc_p1 <= acc_nxt;
    else if (acc_clr) acc_p1 <= '0;
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign enc_word       = raw_word;
`endif

  // Stage p0 -> p1: assembled word moves into the output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else begin
      cnt_p0 <= cnt_nxt;
      if (xfer) begin
        word_p1 <= enc_word;
        vld_p1  <= 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    asm_p0 <= asm_wr;
  end

  assign sym_i     = word_p1[BPS-1:BPS/2];
  assign sym_q     = word_p1[BPS/2-1:0];
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_qam_s2p_diff.sv
// Bench for qam_s2p_diff: BPS=4 LSB-first and BPS=6 MSB-first instances, scoreboard plus directed checks.
module tb_qam_s2p_diff;
`ifdef QAM_S2P_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic       clk, rst_n;
  logic       in_bit4, in_valid4, in_ready4, acc_clr4, out_valid4, out_ready4;
  logic [1:0] sym_i4, sym_q4;
  logic       in_bit6, in_valid6, in_ready6, acc_clr6, out_valid6, out_ready6;
  logic [2:0] sym_i6, sym_q6;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] q4[$];
  logic [7:0] q6[$];
  logic [3:0] mw4;
  logic [5:0] mw6;
  int         nb4, nb6, macc4, macc6;
  logic       got4, got6;
  logic [11:0] bp;

  qam_s2p_diff #(.BPS(4), .LSB_FIRST(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit4), .in_valid(in_valid4), .in_ready(in_ready4),
    .acc_clr(acc_clr4), .sym_i(sym_i4), .sym_q(sym_q4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  qam_s2p_diff #(.BPS(6), .LSB_FIRST(1'b0)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit6), .in_valid(in_valid6), .in_ready(in_ready6),
    .acc_clr(acc_clr6), .sym_i(sym_i6), .sym_q(sym_q6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q4.delete(); q6.delete();
    nb4 = 0; nb6 = 0; macc4 = 0; macc6 = 0;
    mw4 = '0; mw6 = '0;
  endtask

  // Sample handshakes away from the edge, update the model, then advance one clock.
  task automatic step();
    #1;
    got4 = in_valid4 && in_ready4;
    got6 = in_valid6 && in_ready6;
    if (out_valid4 && out_ready4) begin
      chk("sb4_nonempty", 32'(q4.size() > 0), 1);
      if (q4.size() > 0) chk("sym4", {sym_i4, sym_q4}, q4.pop_front());
    end
    if (out_valid6 && out_ready6) begin
      chk("sb6_nonempty", 32'(q6.size() > 0), 1);
      if (q6.size() > 0) chk("sym6", {sym_i6, sym_q6}, q6.pop_front());
    end
    if (acc_clr4) macc4 = 0;
    if (got4) begin
      mw4[nb4] = in_bit4;
      nb4++;
      if (nb4 == 4) begin
        macc4 = (macc4 + int'(mw4)) % 16;
        q4.push_back(DIFF ? 8'(macc4 ^ (macc4 >> 1)) : {4'b0, mw4});
        nb4 = 0;
      end
    end
    if (got6) begin
      mw6[5 - nb6] = in_bit6;
      nb6++;
      if (nb6 == 6) begin
        macc6 = (macc6 + int'(mw6)) % 64;
        q6.push_back(DIFF ? 8'(macc6 ^ (macc6 >> 1)) : {2'b0, mw6});
        nb6 = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic b, input logic clr);
    in_bit4 = b; in_valid4 = 1'b1; acc_clr4 = clr;
    got4 = 1'b0;
    for (int w = 0; w < 16 && !got4; w++) step();
    chk("accept4", got4, 1);
    in_valid4 = 1'b0; acc_clr4 = 1'b0;
  endtask

  task automatic send6(input logic b);
    in_bit6 = b; in_valid6 = 1'b1;
    got6 = 1'b0;
    for (int w = 0; w < 16 && !got6; w++) step();
    chk("accept6", got6, 1);
    in_valid6 = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid4 = 1'b0; in_valid6 = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    in_bit4 = 0; in_valid4 = 0; acc_clr4 = 0; out_ready4 = 1;
    in_bit6 = 0; in_valid6 = 0; acc_clr6 = 0; out_ready6 = 1;
    got4 = 0; got6 = 0;
    model_reset();
    #12;
    chk("rst_in_ready4", in_ready4, 1);
    chk("rst_out_valid4", out_valid4, 0);
    chk("rst_sym4", {sym_i4, sym_q4}, 0);
    chk("rst_in_ready6", in_ready6, 1);
    chk("rst_out_valid6", out_valid6, 0);
    chk("rst_sym6", {sym_i6, sym_q6}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bits 1,0,1,1 twice: plain 1101 both times; differential Gray 1011 then 1111.
    send4(1, 0); send4(0, 0); send4(1, 0);
    chk("lat_pre", out_valid4, 0);
    send4(1, 0);
    chk("w1_valid", out_valid4, 1);
    chk("w1_sym", {sym_i4, sym_q4}, DIFF ? 4'hB : 4'hD);
    send4(1, 0); send4(0, 0); send4(1, 0); send4(1, 0);
    chk("w2_valid", out_valid4, 1);
    chk("w2_sym", {sym_i4, sym_q4}, DIFF ? 4'hF : 4'hD);
    idle(1);

    // Backpressure: two words against a stalled output, then a single-cycle release.
    bp = 12'b1100_1011_0010;
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) send4(bp[i], 0);
    chk("bp_a_valid", out_valid4, 1);
    for (int i = 4; i < 8; i++) send4(bp[i], 0);
    chk("bp_hold", {sym_i4, sym_q4}, q4[0]);
    chk("bp_in_ready_low", in_ready4, 0);
    chk("bp_valid_hold", out_valid4, 1);
    in_bit4 = bp[8]; in_valid4 = 1'b1;
    step();
    chk("bp_stall_noacc", got4, 0);
    chk("bp_hold2", {sym_i4, sym_q4}, q4[0]);
    out_ready4 = 1'b1;
    #1;
    chk("bp_in_ready_ret", in_ready4, 1);
    step();
    out_ready4 = 1'b0; in_valid4 = 1'b0;
    chk("bp_got_c0", got4, 1);
    chk("bp_b_valid", out_valid4, 1);
    chk("bp_b_sym", {sym_i4, sym_q4}, q4[0]);
    chk("bp_in_ready_c", in_ready4, 1);
    out_ready4 = 1'b1;
    for (int i = 9; i < 12; i++) send4(bp[i], 0);
    idle(1);

    // Clear coinciding with the transfer of a second 13: output is Gray(13) in differential mode.
    send4(1, 0); send4(0, 0); send4(1, 0); send4(1, 0);
    send4(1, 0); send4(0, 0); send4(1, 0); send4(1, 1);
    chk("clr_valid", out_valid4, 1);
    chk("clr_sym", {sym_i4, sym_q4}, DIFF ? 4'hB : 4'hD);
    idle(1);

    // BPS=6 MSB-first: bits 1,0,0,0,0,1 -> 100001 (differential Gray 110001).
    send6(1); send6(0); send6(0); send6(0); send6(0); send6(1);
    chk("b6_valid", out_valid6, 1);
    chk("b6_sym", {sym_i6, sym_q6}, DIFF ? 6'h31 : 6'h21);
    idle(1);

    // Reset with a held symbol and a half-assembled word.
    out_ready4 = 1'b0;
    send4(1, 0); send4(1, 0); send4(1, 0); send4(0, 0);
    send4(1, 0); send4(1, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid4, 0);
    chk("arst_sym", {sym_i4, sym_q4}, 0);
    chk("arst_in_ready", in_ready4, 1);
    model_reset();
    #2;
    rst_n = 1'b1;
    out_ready4 = 1'b1;
    send4(0, 0); send4(1, 0); send4(1, 0); send4(0, 0);
    chk("arst_next_valid", out_valid4, 1);
    chk("arst_next_sym", {sym_i4, sym_q4}, DIFF ? 4'h5 : 4'h6);
    idle(2);

    // Sustained stream: a bit every cycle with no bubble between words.
    for (int i = 0; i < 12; i++) begin
      in_bit4 = 1'($urandom_range(0, 1));
      in_valid4 = 1'b1;
      #1;
      chk("tput_ready", in_ready4, 1);
      step();
    end
    in_valid4 = 1'b0;
    idle(2);

    chk("sb4_drained", q4.size(), 0);
    chk("sb6_drained", q6.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
